// File: rtl/tx_sched_pkg.sv
// rtl/tx_sched_pkg.sv - symbol constants, scheduler state enum and CRC-8 step function
package tx_sched_pkg;

  localparam logic [7:0] K28_5     = 8'hBC;
  localparam logic [7:0] K27_7     = 8'hFB;
  localparam logic [7:0] K29_7     = 8'hFD;
  localparam logic [7:0] K30_7     = 8'hFE;
  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_CRC,
    ST_EOF,
    ST_ABORT
  } state_t;

  // Byte-at-a-time CRC-8, MSB first
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/tx_frame_sched_if.sv
// rtl/tx_frame_sched_if.sv - packet source byte stream into the frame scheduler
interface tx_frame_sched_if;

  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/tx_crc8.sv
// rtl/tx_crc8.sv - registered CRC-8 (poly 0x07, init 0x00) with clear and byte enable
import tx_sched_pkg::*;

module tx_crc8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= 8'h00;
    end else if (clr) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= crc8_next(crc, data);
    end
  end

endmodule

// File: rtl/tx_frame_sched.sv
// rtl/tx_frame_sched.sv - SOF/payload/EOF symbol scheduler with K28.5 fill ahead of the 8b/10b encoder
// Optional CRC-8 trailer byte before EOF when TX_FRAME_SCHED_CRC8_EN is defined.
import tx_sched_pkg::*;

module tx_frame_sched #(
  parameter int MAX_LEN  = 256,
  parameter int IDLE_MIN = 4
) (
  input  logic            clk,
  input  logic            reset,
  tx_frame_sched_if.slave src,
  output logic            enc_k,
  output logic [7:0]      enc_eb,
  output logic            busy,
  output logic            frame_done,
  output logic            abort
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int GAP_W = $clog2(IDLE_MIN + 1);
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IDLE_MIN);

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             enc_k_d, busy_d, done_d, abort_d;
  logic [7:0]       enc_eb_d;

`ifdef TX_FRAME_SCHED_CRC8_EN
  localparam state_t ST_TAIL = ST_CRC;
  logic [7:0] crc;

  tx_crc8 u_crc (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == ST_SOF),
    .en    (src.s_ready && src.s_valid),
    .data  (src.s_data),
    .crc   (crc)
  );
`else
  localparam state_t ST_TAIL = ST_EOF;
`endif

  assign src.s_ready = (state_q == ST_DATA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gap_q      <= GAP_LOAD;
      len_q      <= '0;
      enc_k      <= 1'b1;
      enc_eb     <= K28_5;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      abort      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      len_q      <= len_d;
      enc_k      <= enc_k_d;
      enc_eb     <= enc_eb_d;
      busy       <= busy_d;
      frame_done <= done_d;
      abort      <= abort_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    len_d    = len_q;
    enc_k_d  = 1'b1;
    enc_eb_d = K28_5;
    busy_d   = busy;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The comma emitted on the edge that leaves IDLE is the last one of the gap
        if (gap_q != '0) gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1) && src.s_valid) state_d = ST_SOF;
      end
      ST_SOF: begin
        enc_eb_d = K27_7;
        busy_d   = 1'b1;
        len_d    = '0;
        state_d  = ST_DATA;
      end
      ST_DATA: begin
        if (src.s_valid) begin
          enc_k_d  = 1'b0;
          enc_eb_d = src.s_data;
          len_d    = len_q + LEN_W'(1);
          if (src.s_last)            state_d = ST_TAIL;
          else if (len_q == LEN_LAST) state_d = ST_ABORT;
        end else begin
          // Underrun: the abort symbol replaces the missing byte directly
          enc_eb_d = K30_7;
          abort_d  = 1'b1;
          busy_d   = 1'b0;
          gap_d    = GAP_LOAD;
          state_d  = ST_IDLE;
        end
      end
`ifdef TX_FRAME_SCHED_CRC8_EN
      ST_CRC: begin
        enc_k_d  = 1'b0;
        enc_eb_d = crc;
        state_d  = ST_EOF;
      end
`endif
      ST_EOF: begin
        enc_eb_d = K29_7;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        gap_d    = GAP_LOAD;
        state_d  = ST_IDLE;
      end
      ST_ABORT: begin
        enc_eb_d = K30_7;
        abort_d  = 1'b1;
        busy_d   = 1'b0;
        gap_d    = GAP_LOAD;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
